// File: rtl/cpu_jtag_scan_initiator_if.sv
// cpu_jtag_scan_initiator_if: scan command/response handshake plus virtual-JTAG strobes.
interface cpu_jtag_scan_initiator_if #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2
);
   logic                cmd_valid, cmd_ready, cmd_skip_ir;
   logic [IR_WIDTH-1:0] cmd_ir;
   logic [DR_WIDTH-1:0] cmd_dr;
   logic                rsp_valid, rsp_ready;
   logic [DR_WIDTH-1:0] rsp_dr;
   logic [IR_WIDTH-1:0] rsp_ir_out;
   logic                busy;
   logic                vji_tck, vji_tdi, vji_tdo;
   logic [IR_WIDTH-1:0] vji_ir_in, vji_ir_out;
   logic                vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr;
   modport slave (
      input  cmd_valid, cmd_ir, cmd_skip_ir, cmd_dr, rsp_ready, vji_tdo, vji_ir_out,
      output cmd_ready, rsp_valid, rsp_dr, rsp_ir_out, busy, vji_tck, vji_tdi, vji_ir_in,
             vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr
   );
   modport master (
      output cmd_valid, cmd_ir, cmd_skip_ir, cmd_dr, rsp_ready, vji_tdo, vji_ir_out,
      input  cmd_ready, rsp_valid, rsp_dr, rsp_ir_out, busy, vji_tck, vji_tdi, vji_ir_in,
             vji_rti, vji_uir, vji_cdr, vji_sdr, vji_udr
   );
endinterface

// File: rtl/cpu_jtag_scan_initiator.sv
// cpu_jtag_scan_initiator: runs one UIR/CDR/SDR/UDR virtual-JTAG scan per command and returns the DR word.
module cpu_jtag_scan_initiator #(
   parameter int DR_WIDTH = 38,
   parameter int IR_WIDTH = 2,
   parameter int HALF_DIV = 2
) (
   input logic clk,
   input logic reset,
   cpu_jtag_scan_initiator_if.slave bus
);
   localparam int PW = $clog2(2 * HALF_DIV);
   localparam int BW = $clog2(DR_WIDTH);
   localparam logic [PW-1:0] PH_LOW = PW'(HALF_DIV - 1);
   localparam logic [PW-1:0] PH_END = PW'(2 * HALF_DIV - 1);
   localparam logic [BW-1:0] BIT_END = BW'(DR_WIDTH - 1);
   typedef enum logic [2:0] {IDLE, UIR, CDR, SDR, UDR, RSP} state_t;
   state_t              state_q;
   logic [PW-1:0]       ph_q;
   logic [BW-1:0]       bit_q;
   logic [DR_WIDTH-1:0] shreg_q, rsp_dr_q;
   logic [IR_WIDTH-1:0] ir_q, rsp_ir_q;
   logic                tck_q, rsp_valid_q;
   logic                scan, low_last, ph_last;
   assign scan     = state_q inside {UIR, CDR, SDR, UDR};
   assign low_last = ph_q == PH_LOW;
   assign ph_last  = ph_q == PH_END;
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         ph_q        <= '0;
         bit_q       <= '0;
         shreg_q     <= '0;
         rsp_dr_q    <= '0;
         ir_q        <= '0;
         rsp_ir_q    <= '0;
         tck_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         // phase counter and TCK wrap together, so every phase ends with TCK low
         ph_q  <= (scan && !ph_last) ? ph_q + PW'(1) : '0;
         tck_q <= scan && (low_last || (tck_q && !ph_last));
         case (state_q)
            IDLE: if (bus.cmd_valid) begin
               shreg_q <= bus.cmd_dr;
               bit_q   <= '0;
               if (!bus.cmd_skip_ir) ir_q <= bus.cmd_ir;
               state_q <= bus.cmd_skip_ir ? CDR : UIR;
            end
            UIR: if (ph_last) state_q <= CDR;
            CDR: if (ph_last) begin
               rsp_ir_q <= bus.vji_ir_out;
               state_q  <= SDR;
            end
            SDR: begin
               if (low_last) shreg_q <= {bus.vji_tdo, shreg_q[DR_WIDTH-1:1]};
               if (ph_last) begin
                  bit_q <= bit_q + BW'(1);
                  if (bit_q == BIT_END) state_q <= UDR;
               end
            end
            UDR: if (ph_last) begin
               rsp_dr_q    <= shreg_q;
               rsp_valid_q <= 1'b1;
               state_q     <= RSP;
            end
            RSP: if (bus.rsp_ready) begin
               rsp_valid_q <= 1'b0;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.cmd_ready  = state_q == IDLE;
   assign bus.busy       = state_q != IDLE;
   assign bus.rsp_valid  = rsp_valid_q;
   assign bus.rsp_dr     = rsp_dr_q;
   assign bus.rsp_ir_out = rsp_ir_q;
   assign bus.vji_tck    = tck_q;
   assign bus.vji_tdi    = state_q == SDR && !tck_q && shreg_q[0];
   assign bus.vji_ir_in  = ir_q;
   assign bus.vji_rti    = state_q == IDLE;
   assign bus.vji_uir    = state_q == UIR;
   assign bus.vji_cdr    = state_q == CDR;
   assign bus.vji_sdr    = state_q == SDR;
   assign bus.vji_udr    = state_q == UDR;
endmodule

// File: tb/tb_cpu_jtag_scan_initiator.sv
// tb_cpu_jtag_scan_initiator: directed scans against loopback/constant TDO with hand-computed results.
module tb_cpu_jtag_scan_initiator;
   localparam int DRW = 38;
   logic clk = 1'b0;
   logic reset = 1'b1;
   logic loop_en = 1'b0;
   logic tdo_const = 1'b0;
   int   tests = 0, fails = 0;
   int   sdr_edges = 0, uir_cnt = 0, udr_cnt = 0, rsp_cnt = 0;
   cpu_jtag_scan_initiator_if #(.DR_WIDTH(DRW), .IR_WIDTH(2)) bus ();
   cpu_jtag_scan_initiator #(.DR_WIDTH(DRW), .IR_WIDTH(2), .HALF_DIV(2)) dut (
      .clk(clk), .reset(reset), .bus(bus)
   );
   assign bus.vji_tdo = loop_en ? bus.vji_tdi : tdo_const;
   always #5 clk = ~clk;
   always @(posedge bus.vji_tck) if (bus.vji_sdr) sdr_edges++;
   always @(posedge bus.vji_uir) uir_cnt++;
   always @(posedge bus.vji_udr) udr_cnt++;
   always @(posedge bus.rsp_valid) rsp_cnt++;

   task automatic send(input logic [1:0] ir, input logic [DRW-1:0] dr, input logic skip);
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_ir = ir;
      bus.cmd_dr = dr;
      bus.cmd_skip_ir = skip;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!bus.rsp_valid && lat < 400) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic take;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
   endtask

   task automatic test_reset;
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if ({bus.cmd_ready, bus.busy, bus.vji_rti} !== 3'b101) begin
         fails++;
         $display("FAIL reset_status: got ready/busy/rti=%b required 101", {bus.cmd_ready, bus.busy, bus.vji_rti});
      end
      tests++;
      if ({bus.vji_tck, bus.vji_tdi, bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr} !== 6'b0) begin
         fails++;
         $display("FAIL reset_tap: got tck/tdi/uir/cdr/sdr/udr=%b required 000000",
                  {bus.vji_tck, bus.vji_tdi, bus.vji_uir, bus.vji_cdr, bus.vji_sdr, bus.vji_udr});
      end
      tests++;
      if ({bus.rsp_valid, bus.rsp_dr, bus.rsp_ir_out, bus.vji_ir_in} !== '0) begin
         fails++;
         $display("FAIL reset_rsp: got valid=%b dr=%h irout=%b irin=%b required all zero",
                  bus.rsp_valid, bus.rsp_dr, bus.rsp_ir_out, bus.vji_ir_in);
      end
      reset = 1'b0;
   endtask

   task automatic test_loopback;
      int lat;
      loop_en = 1'b1;
      uir_cnt = 0;
      send(2'd2, 38'h2A_5A5A_5A5A, 1'b0);
      wait_rsp(lat);
      tests++;
      if (lat !== 165) begin
         fails++;
         $display("FAIL loop_latency: got cycle %0d required 165", lat);
      end
      tests++;
      if (bus.rsp_dr !== 38'h2A_5A5A_5A5A) begin
         fails++;
         $display("FAIL loop_data: got %h required 2a5a5a5a5a", bus.rsp_dr);
      end
      tests++;
      if (bus.vji_ir_in !== 2'd2 || uir_cnt !== 1) begin
         fails++;
         $display("FAIL loop_ir: got ir_in=%0d uir_pulses=%0d required 2 and 1", bus.vji_ir_in, uir_cnt);
      end
      take();
   endtask

   task automatic test_tdo_ones;
      int lat;
      loop_en = 1'b0;
      tdo_const = 1'b1;
      sdr_edges = 0;
      send(2'd2, '0, 1'b0);
      wait_rsp(lat);
      tests++;
      if (bus.rsp_dr !== {DRW{1'b1}}) begin
         fails++;
         $display("FAIL ones_data: got %h required 3fffffffff", bus.rsp_dr);
      end
      tests++;
      if (sdr_edges !== DRW) begin
         fails++;
         $display("FAIL ones_tck_edges: got %0d required %0d", sdr_edges, DRW);
      end
      take();
   endtask

   task automatic test_skip_ir;
      int lat;
      loop_en = 1'b1;
      uir_cnt = 0;
      send(2'd1, 38'h15_0F0F_1234, 1'b1);
      wait_rsp(lat);
      tests++;
      if (lat !== 161) begin
         fails++;
         $display("FAIL skip_latency: got cycle %0d required 161", lat);
      end
      tests++;
      if (uir_cnt !== 0 || bus.vji_ir_in !== 2'd2) begin
         fails++;
         $display("FAIL skip_ir: got uir_pulses=%0d ir_in=%0d required 0 and 2", uir_cnt, bus.vji_ir_in);
      end
      tests++;
      if (bus.rsp_dr !== 38'h15_0F0F_1234) begin
         fails++;
         $display("FAIL skip_data: got %h required 150f0f1234", bus.rsp_dr);
      end
      take();
   endtask

   task automatic test_backpressure;
      int lat, bad;
      bad = 0;
      send(2'd3, 38'h01_2345_6789, 1'b0);
      wait_rsp(lat);
      repeat (20) begin
         @(posedge clk);
         #1;
         if (!bus.rsp_valid || bus.rsp_dr !== 38'h01_2345_6789 || bus.cmd_ready) bad++;
      end
      tests++;
      if (bad !== 0) begin
         fails++;
         $display("FAIL hold_stable: got %0d unstable cycles required 0 (dr=%h)", bad, bus.rsp_dr);
      end
      bus.rsp_ready = 1'b1;
      #1;
      tests++;
      if (bus.cmd_ready !== 1'b0) begin
         fails++;
         $display("FAIL no_turnaround: got cmd_ready=%b required 0", bus.cmd_ready);
      end
      @(posedge clk);
      #1;
      bus.rsp_ready = 1'b0;
      tests++;
      if ({bus.rsp_valid, bus.cmd_ready, bus.busy} !== 3'b010) begin
         fails++;
         $display("FAIL release_idle: got valid/ready/busy=%b required 010", {bus.rsp_valid, bus.cmd_ready, bus.busy});
      end
   endtask

   task automatic test_reset_mid_scan;
      int n;
      n = 0;
      udr_cnt = 0;
      rsp_cnt = 0;
      sdr_edges = 0;
      send(2'd1, 38'h3A_BCDE_F012, 1'b0);
      while (sdr_edges < 10 && n < 500) begin
         @(posedge clk);
         n++;
      end
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      tests++;
      if ({bus.cmd_ready, bus.vji_tck, bus.vji_sdr, bus.rsp_valid} !== 4'b1000) begin
         fails++;
         $display("FAIL abort_state: got ready/tck/sdr/valid=%b required 1000 (waited %0d)",
                  {bus.cmd_ready, bus.vji_tck, bus.vji_sdr, bus.rsp_valid}, n);
      end
      reset = 1'b0;
      repeat (200) @(posedge clk);
      #1;
      tests++;
      if (udr_cnt !== 0 || rsp_cnt !== 0 || bus.rsp_valid !== 1'b0) begin
         fails++;
         $display("FAIL abort_silent: got udr=%0d rsp=%0d valid=%b required 0 0 0", udr_cnt, rsp_cnt, bus.rsp_valid);
      end
   endtask

   task automatic test_ir_out_busy;
      int lat;
      loop_en = 1'b1;
      rsp_cnt = 0;
      bus.vji_ir_out = 2'b01;
      send(2'd2, 38'h3F_0000_00C3, 1'b0);
      repeat (20) @(posedge clk);
      #1;
      bus.cmd_valid = 1'b1;
      bus.cmd_dr = 38'h11_1111_1111;
      bus.cmd_skip_ir = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.vji_ir_out = 2'b10;
      wait_rsp(lat);
      tests++;
      if (bus.rsp_ir_out !== 2'b01) begin
         fails++;
         $display("FAIL ir_out: got %b required 01", bus.rsp_ir_out);
      end
      tests++;
      if (bus.rsp_dr !== 38'h3F_0000_00C3) begin
         fails++;
         $display("FAIL busy_ignore_data: got %h required 3f000000c3", bus.rsp_dr);
      end
      take();
      repeat (200) @(posedge clk);
      #1;
      tests++;
      if (rsp_cnt !== 1 || bus.busy !== 1'b0) begin
         fails++;
         $display("FAIL single_response: got %0d responses busy=%b required 1 and 0", rsp_cnt, bus.busy);
      end
   endtask

   initial begin
      bus.cmd_valid = 1'b0;
      bus.cmd_ir = '0;
      bus.cmd_dr = '0;
      bus.cmd_skip_ir = 1'b0;
      bus.rsp_ready = 1'b0;
      bus.vji_ir_out = '0;
      test_reset();
      test_loopback();
      test_tdo_ones();
      test_skip_ir();
      test_backpressure();
      test_reset_mid_scan();
      test_ir_out_busy();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
